// File: rtl/ecc_cfg_pkg.sv
// Shared types for the ECC configuration sequencer: register offsets, operation
// and FSM encodings, and the transfer-slot ordering used by the index counter.
package ecc_cfg_pkg;

    localparam logic [3:0] CTRL_OFFSET           = 4'h0;
    localparam logic [3:0] DATA_IN_OFFSET        = 4'h4;
    localparam logic [3:0] CODEWORD_WIDTH_OFFSET = 4'h8;
    localparam logic [3:0] NOISE_OFFSET          = 4'hC;

    typedef enum logic [1:0] {
        ENCODE       = 2'b00,
        DECODE       = 2'b01,
        FULL_CHANNEL = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_e;

    // Slot value is the transfer index; CTRL is last so it triggers the ECC block.
    typedef enum logic [1:0] {
        SLOT_DATA_IN = 2'd0,
        SLOT_WIDTH   = 2'd1,
        SLOT_NOISE   = 2'd2,
        SLOT_CTRL    = 2'd3
    } slot_e;

    function automatic logic [3:0] slot_offset(input slot_e slot);
        case (slot)
            SLOT_DATA_IN: return DATA_IN_OFFSET;
            SLOT_WIDTH:   return CODEWORD_WIDTH_OFFSET;
            SLOT_NOISE:   return NOISE_OFFSET;
            default:      return CTRL_OFFSET;
        endcase
    endfunction

    // The reserved encoding behaves as a full-channel operation.
    function automatic op_e decode_op(input logic [1:0] raw);
        return (raw == 2'b11) ? FULL_CHANNEL : op_e'(raw);
    endfunction

endpackage

// File: rtl/ecc_apb_xfer.sv
// APB transfer engine: sequences SETUP/ACCESS for the transfer the parent presents,
// counts ACCESS wait cycles for the timeout, and hands read data back on completion.
module ecc_apb_xfer
    import ecc_cfg_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int TIMEOUT         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       last,
    input  logic                       write,
    input  logic [AMBA_ADDR_WIDTH-1:0] addr,
    input  logic [AMBA_WORD-1:0]       wdata,
    input  logic [AMBA_WORD-1:0]       prdata,
    input  logic                       pready,
    output state_e                     state,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [AMBA_ADDR_WIDTH-1:0] paddr,
    output logic [AMBA_WORD-1:0]       pwdata,
    output logic                       xfer_ok,
    output logic                       timeout,
    output logic                       finish,
    output logic                       rdata_valid,
    output logic [AMBA_WORD-1:0]       rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e           state_next;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // The current ACCESS cycle counts toward the limit, so ACCESS lasts at most TIMEOUT cycles.
    assign timeout     = (state == ACCESS) && !pready && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign xfer_ok     = (state == ACCESS) && pready;
    assign finish      = (xfer_ok && last) || timeout;
    assign rdata_valid = xfer_ok && !write;
    assign rdata       = prdata;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (finish)       state_next = DONE;
                else if (xfer_ok) state_next = SETUP;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        if (state == SETUP || state == ACCESS) begin
            psel    = 1'b1;
            penable = (state == ACCESS);
            pwrite  = write;
            paddr   = addr;
            pwdata  = write ? wdata : '0;
        end
    end

endmodule

// File: rtl/ecc_cfg_sequencer.sv
// Programs the ECC register bank for one command: writes DATA_IN, CODEWORD_WIDTH,
// optional NOISE, then CTRL, optionally reads them back, and reports status.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, and all cmd_* fields are captured on that edge.
module ecc_cfg_sequencer
    import ecc_cfg_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int BASE_ADDR       = 0,
    parameter int READBACK        = 1,
    parameter int TIMEOUT         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [1:0]                 cmd_width,
    input  logic [DATA_WIDTH-1:0]      cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] paddr,
    output logic [AMBA_WORD-1:0]       pwdata,
    output logic                       pwrite,
    output logic                       psel,
    output logic                       penable,
    input  logic [AMBA_WORD-1:0]       prdata,
    input  logic                       pready,
    output logic                       done,
    output logic                       err_mismatch,
    output logic                       err_timeout
);

    state_e                     state;
    logic                       start;
    logic                       last;
    logic                       xfer_ok;
    logic                       timeout;
    logic                       finish;
    logic                       rdata_valid;
    logic [AMBA_WORD-1:0]       rdata;

    op_e                        op_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [DATA_WIDTH-1:0]      noise_q;
    logic [1:0]                 width_q;
    slot_e                      slot_q;
    slot_e                      slot_next;
    logic                       read_phase_q;
    logic                       mismatch_seen_q;

    logic [AMBA_WORD-1:0]       slot_value;
    logic [AMBA_ADDR_WIDTH-1:0] slot_addr;
    logic                       mismatch_now;

    assign cmd_ready = (state == IDLE);
    assign start     = cmd_valid && cmd_ready;
    assign done      = (state == DONE);

    always_comb begin
        slot_value = '0;
        case (slot_q)
            SLOT_DATA_IN: slot_value = AMBA_WORD'(data_q);
            SLOT_WIDTH:   slot_value = AMBA_WORD'(width_q);
            SLOT_NOISE:   slot_value = AMBA_WORD'(noise_q);
            SLOT_CTRL:    slot_value = AMBA_WORD'(op_q);
            default:      slot_value = '0;
        endcase
    end

    always_comb begin
        slot_next = slot_e'(slot_q + 2'd1);
        if (slot_q == SLOT_WIDTH && op_q != FULL_CHANNEL) begin
            slot_next = SLOT_CTRL;
        end
    end

    assign slot_addr    = AMBA_ADDR_WIDTH'(BASE_ADDR) + AMBA_ADDR_WIDTH'(slot_offset(slot_q));
    assign last         = (slot_q == SLOT_CTRL) && (read_phase_q || READBACK == 0);
    assign mismatch_now = rdata_valid && (rdata != slot_value);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q            <= ENCODE;
            data_q          <= '0;
            noise_q         <= '0;
            width_q         <= '0;
            slot_q          <= SLOT_DATA_IN;
            read_phase_q    <= 1'b0;
            mismatch_seen_q <= 1'b0;
            err_mismatch    <= 1'b0;
            err_timeout     <= 1'b0;
        end else if (start) begin
            op_q            <= decode_op(cmd_op);
            data_q          <= cmd_data;
            noise_q         <= cmd_noise;
            width_q         <= cmd_width;
            slot_q          <= SLOT_DATA_IN;
            read_phase_q    <= 1'b0;
            mismatch_seen_q <= 1'b0;
            err_mismatch    <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            // After CTRL the list restarts from DATA_IN for the readback pass.
            if (xfer_ok) begin
                if (slot_q == SLOT_CTRL) begin
                    slot_q       <= SLOT_DATA_IN;
                    read_phase_q <= 1'b1;
                end else begin
                    slot_q <= slot_next;
                end
            end
            if (mismatch_now) begin
                mismatch_seen_q <= 1'b1;
            end
            if (finish) begin
                err_mismatch <= mismatch_seen_q || mismatch_now;
                err_timeout  <= timeout;
            end
        end
    end

    ecc_apb_xfer #(
        .AMBA_WORD       (AMBA_WORD),
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
        .TIMEOUT         (TIMEOUT)
    ) u_xfer (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .last        (last),
        .write       (!read_phase_q),
        .addr        (slot_addr),
        .wdata       (slot_value),
        .prdata      (prdata),
        .pready      (pready),
        .state       (state),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .xfer_ok     (xfer_ok),
        .timeout     (timeout),
        .finish      (finish),
        .rdata_valid (rdata_valid),
        .rdata       (rdata)
    );

endmodule
